// File: rtl/rx_wb_capture_if.sv
// Wideband sample-read bus plus the sample-RAM write port, as seen by rx_wb_capture.
// The master is the capture sequencer; the slave is the receiver/RAM side.
interface rx_wb_capture_if #(
    parameter int unsigned AW = 16
);
    logic          rx_avail_wb;
    logic [15:0]   rx_dout;
    logic          rd_getI;
    logic          rd_getQ;
    logic          rd_getWB;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [15:0]   ram_wdata;

    modport master (
        input  rx_avail_wb,
        input  rx_dout,
        output rd_getI,
        output rd_getQ,
        output rd_getWB,
        output ram_we,
        output ram_waddr,
        output ram_wdata
    );

    modport slave (
        output rx_avail_wb,
        output rx_dout,
        input  rd_getI,
        input  rd_getQ,
        input  rd_getWB,
        input  ram_we,
        input  ram_waddr,
        input  ram_wdata
    );
endinterface

// File: rtl/rx_wb_capture.sv
// Capture sequencer: reads I, Q and packed-MSB words per wideband strobe into a ping-pong RAM.
// Define RX_WB_CAPTURE_HDR_EN to prefix each half with a 3-word header.
module rx_wb_capture #(
    parameter int unsigned NSAMP = 512,
    parameter int unsigned AW    = 16
) (
    input  logic             adc_clk,
    input  logic             reset,
    input  logic             enable,
    rx_wb_capture_if.master  bus,
    output logic [1:0]       buf_rdy,
    input  logic             cpu_ack,
    input  logic             ack_half,
    output logic [15:0]      ovfl_cnt,
    output logic [2:0]       didx_o,
    output logic [15:0]      waddr_o,
    output logic [15:0]      count_o
);
    localparam int unsigned CW = (NSAMP > 1) ? $clog2(NSAMP) : 1;
`ifdef RX_WB_CAPTURE_HDR_EN
    localparam int unsigned SPP = NSAMP - 1;
`else
    localparam int unsigned SPP = NSAMP;
`endif
    localparam logic [CW-1:0] LastCount = CW'(SPP - 1);
    localparam logic [AW-1:0] LastAddr  = AW'(6 * NSAMP - 1);

    typedef enum logic [2:0] {
        StIdle, StRdI, StRdQ, StRdX, StHdr0, StHdr1, StHdr2
    } state_e;

    state_e        state_q, state_d;
    logic          half_q, half_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [1:0]    buf_rdy_q, buf_rdy_d;
    logic [15:0]   ovfl_q, ovfl_d;
    logic          sel_i_q, sel_i_d;
    logic          sel_q_q, sel_q_d;
    logic          sel_wb_q, sel_wb_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [15:0]   wdata_q, wdata_d;
`ifdef RX_WB_CAPTURE_HDR_EN
    logic          hdr_pend_q, hdr_pend_d;
    logic [15:0]   hdr_ovfl_q, hdr_ovfl_d;
`endif

    logic          avail;
    logic          accept;
    logic          wr;
    logic [15:0]   wr_data;

    always_comb begin
        avail  = bus.rx_avail_wb && enable;
        accept = avail && (state_q == StIdle) && !buf_rdy_q[half_q];

        state_d   = state_q;
        half_d    = half_q;
        count_d   = count_q;
        wptr_d    = wptr_q;
        buf_rdy_d = buf_rdy_q;
        ovfl_d    = ovfl_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wr        = 1'b0;
        wr_data   = bus.rx_dout;
`ifdef RX_WB_CAPTURE_HDR_EN
        hdr_pend_d = hdr_pend_q;
        hdr_ovfl_d = hdr_ovfl_q;
`endif

        // Clear first so a completing fill of the same half overrides the ack.
        if (cpu_ack) begin
            buf_rdy_d[ack_half] = 1'b0;
        end
        if (avail && !accept && (ovfl_q != 16'hFFFF)) begin
            ovfl_d = ovfl_q + 16'd1;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef RX_WB_CAPTURE_HDR_EN
                    if (hdr_pend_q) begin
                        state_d    = StHdr0;
                        hdr_pend_d = 1'b0;
                        hdr_ovfl_d = ovfl_q;
                    end else begin
                        state_d = StRdI;
                    end
`else
                    state_d = StRdI;
`endif
                end
            end
            StRdI: begin
                state_d = StRdQ;
                wr      = 1'b1;
            end
            StRdQ: begin
                state_d = StRdX;
                wr      = 1'b1;
            end
            StRdX: begin
                state_d = StIdle;
                wr      = 1'b1;
                if (count_q == LastCount) begin
                    buf_rdy_d[half_q] = 1'b1;
                    half_d            = ~half_q;
                    count_d           = '0;
`ifdef RX_WB_CAPTURE_HDR_EN
                    hdr_pend_d        = 1'b1;
`endif
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
`ifdef RX_WB_CAPTURE_HDR_EN
            StHdr0: begin
                state_d = StHdr1;
                wr      = 1'b1;
                wr_data = 16'hC0DE;
            end
            StHdr1: begin
                state_d = StHdr2;
                wr      = 1'b1;
                wr_data = {15'd0, half_q};
            end
            StHdr2: begin
                state_d = StRdI;
                wr      = 1'b1;
                wr_data = hdr_ovfl_q;
            end
`endif
            default: state_d = StIdle;
        endcase

        // The write pointer walks both halves linearly and wraps at the end of half 1.
        if (wr) begin
            we_d    = 1'b1;
            waddr_d = wptr_q;
            wdata_d = wr_data;
            wptr_d  = (wptr_q == LastAddr) ? '0 : wptr_q + AW'(1);
        end

        sel_i_d  = (state_d == StRdI);
        sel_q_d  = (state_d == StRdQ);
        sel_wb_d = (state_d == StRdI) || (state_d == StRdQ) || (state_d == StRdX);
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state_q    <= StIdle;
            half_q     <= 1'b0;
            count_q    <= '0;
            wptr_q     <= '0;
            buf_rdy_q  <= 2'b00;
            ovfl_q     <= 16'd0;
            sel_i_q    <= 1'b0;
            sel_q_q    <= 1'b0;
            sel_wb_q   <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 16'd0;
`ifdef RX_WB_CAPTURE_HDR_EN
            hdr_pend_q <= 1'b1;
            hdr_ovfl_q <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            buf_rdy_q  <= buf_rdy_d;
            ovfl_q     <= ovfl_d;
            sel_i_q    <= sel_i_d;
            sel_q_q    <= sel_q_d;
            sel_wb_q   <= sel_wb_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef RX_WB_CAPTURE_HDR_EN
            hdr_pend_q <= hdr_pend_d;
            hdr_ovfl_q <= hdr_ovfl_d;
`endif
        end
    end

    always_comb begin
        case (state_q)
            StRdI:   didx_o = 3'd0;
            StRdQ:   didx_o = 3'd1;
            StRdX:   didx_o = 3'd2;
`ifdef RX_WB_CAPTURE_HDR_EN
            StHdr0:  didx_o = 3'd3;
            StHdr1:  didx_o = 3'd4;
            StHdr2:  didx_o = 3'd5;
`endif
            default: didx_o = 3'd7;
        endcase
    end

    assign bus.rd_getI   = sel_i_q;
    assign bus.rd_getQ   = sel_q_q;
    assign bus.rd_getWB  = sel_wb_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_waddr = waddr_q;
    assign bus.ram_wdata = wdata_q;
    assign buf_rdy       = buf_rdy_q;
    assign ovfl_cnt      = ovfl_q;
    assign waddr_o       = 16'(waddr_q);
    assign count_o       = 16'(count_q);
endmodule

// File: tb/tb_rx_wb_capture.sv
// Bench for rx_wb_capture: directed and random strobes checked against a schedule-based model.
module tb_rx_wb_capture;
    localparam int unsigned NSAMP = 4;
    localparam int unsigned AW    = 16;
`ifdef RX_WB_CAPTURE_HDR_EN
    localparam int HOFF = 3;
    localparam int SPP  = NSAMP - 1;
`else
    localparam int HOFF = 0;
    localparam int SPP  = NSAMP;
`endif

    logic        adc_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cpu_ack;
    logic        ack_half;
    logic [1:0]  buf_rdy;
    logic [15:0] ovfl_cnt;
    logic [2:0]  didx_o;
    logic [15:0] waddr_o;
    logic [15:0] count_o;
    logic [15:0] di, dq, dx;
    bit          rnd_data;

    rx_wb_capture_if #(.AW(AW)) bus ();

    // Receiver side: read data follows the selects combinationally.
    assign bus.rx_dout = bus.rd_getI ? di : (bus.rd_getQ ? dq : (bus.rd_getWB ? dx : 16'hDEAD));

    rx_wb_capture #(.NSAMP(NSAMP), .AW(AW)) dut (
        .adc_clk  (adc_clk),
        .reset    (reset),
        .enable   (enable),
        .bus      (bus),
        .buf_rdy  (buf_rdy),
        .cpu_ack  (cpu_ack),
        .ack_half (ack_half),
        .ovfl_cnt (ovfl_cnt),
        .didx_o   (didx_o),
        .waddr_o  (waddr_o),
        .count_o  (count_o)
    );

    always #5 adc_clk = ~adc_clk;

    // Model: each accepted strobe schedules its words at absolute select cycles.
    typedef struct {
        int          sel;
        int          kind;
        logic [15:0] addr;
        logic [15:0] hdata;
    } ent_t;

    ent_t        sched[$];
    int          cmp_cyc[$];
    int          cmp_half[$];
    int          cyc;
    int          checks;
    int          errors;
    int          m_half;
    int          m_cnt;
    bit          m_hpend;
    logic [1:0]  e_rdy;
    logic [15:0] e_ovfl;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_data;
    logic [2:0]  e_sel;
    logic [2:0]  e_didx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        cmp_cyc.delete();
        cmp_half.delete();
        m_half  = 0;
        m_cnt   = 0;
        m_hpend = 1'b1;
        e_rdy   = 2'b00;
        e_ovfl  = 16'd0;
        e_we    = 1'b0;
        e_addr  = 16'd0;
        e_data  = 16'd0;
        e_sel   = 3'b000;
        e_didx  = 3'd7;
    endtask

    task automatic model_step(input bit st, input bit en, input bit ack, input bit ah,
                              input bit rst);
        bit busy, acc, drp;
        int base, s;
        if (rst) begin
            model_reset();
            return;
        end
        busy = (sched.size() > 0) && (sched[0].sel == cyc);
        acc  = st && en && !busy && !e_rdy[m_half];
        drp  = st && en && !acc;
        e_we = 1'b0;
        if (busy) begin
            e_we   = 1'b1;
            e_addr = sched[0].addr;
            case (sched[0].kind)
                0:       e_data = di;
                1:       e_data = dq;
                2:       e_data = dx;
                default: e_data = sched[0].hdata;
            endcase
            void'(sched.pop_front());
        end
        if (ack) e_rdy[ah] = 1'b0;
        if ((cmp_cyc.size() > 0) && (cmp_cyc[0] == cyc)) begin
            e_rdy[cmp_half[0]] = 1'b1;
            void'(cmp_cyc.pop_front());
            void'(cmp_half.pop_front());
        end
        if (acc) begin
            base = m_half * 3 * NSAMP;
            s    = cyc + 1;
            if ((HOFF != 0) && m_hpend) begin
                sched.push_back('{s,     3, 16'(base),     16'hC0DE});
                sched.push_back('{s + 1, 4, 16'(base + 1), 16'(m_half)});
                sched.push_back('{s + 2, 5, 16'(base + 2), e_ovfl});
                s       = s + 3;
                m_hpend = 1'b0;
            end
            for (int w = 0; w < 3; w++) begin
                sched.push_back('{s + w, w, 16'(base + HOFF + 3 * m_cnt + w), 16'd0});
            end
            m_cnt++;
            if (m_cnt == SPP) begin
                cmp_cyc.push_back(s + 2);
                cmp_half.push_back(m_half);
                m_cnt   = 0;
                m_half  = 1 - m_half;
                m_hpend = 1'b1;
            end
        end
        if (drp && (e_ovfl != 16'hFFFF)) e_ovfl = e_ovfl + 16'd1;
        e_sel  = 3'b000;
        e_didx = 3'd7;
        if ((sched.size() > 0) && (sched[0].sel == cyc + 1)) begin
            e_didx = 3'(sched[0].kind);
            case (sched[0].kind)
                0:       e_sel = 3'b110;
                1:       e_sel = 3'b101;
                2:       e_sel = 3'b100;
                default: e_sel = 3'b000;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("ram_we", 32'(bus.ram_we), 32'(e_we));
        chk("ram_waddr", 32'(bus.ram_waddr), 32'(e_addr));
        chk("ram_wdata", 32'(bus.ram_wdata), 32'(e_data));
        chk("waddr_o", 32'(waddr_o), 32'(e_addr));
        chk("buf_rdy", 32'(buf_rdy), 32'(e_rdy));
        chk("ovfl_cnt", 32'(ovfl_cnt), 32'(e_ovfl));
        chk("selects", 32'({bus.rd_getWB, bus.rd_getI, bus.rd_getQ}), 32'(e_sel));
        chk("didx_o", 32'(didx_o), 32'(e_didx));
        if (sched.size() == 0) chk("count_o", 32'(count_o), 32'(m_cnt));
    endtask

    task automatic step(input bit st, input bit en, input bit ack, input bit ah, input bit rst);
        bus.rx_avail_wb = st;
        enable          = en;
        cpu_ack         = ack;
        ack_half        = ah;
        reset           = rst;
        if (rnd_data) begin
            di = 16'($urandom);
            dq = 16'($urandom);
            dx = 16'($urandom);
        end
        model_step(st, en, ack, ah, rst);
        @(posedge adc_clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic strobes(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            idle(gap - 1);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rnd_data = 1'b0;
        di       = 16'h1111;
        dq       = 16'h2222;
        dx       = 16'h0303;
        model_reset();

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_didx", 32'(didx_o), 32'd7);
        chk("rst_buf_rdy", 32'(buf_rdy), 32'd0);
        chk("rst_ovfl", 32'(ovfl_cnt), 32'd0);
        chk("rst_we", 32'(bus.ram_we), 32'd0);
        idle(2);

        // Single sample with fixed per-select data.
        strobes(1, 6);

        // Fill both halves at the minimum spacing, then overrun.
        rnd_data = 1'b1;
        strobes(14, 4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        strobes(2, 5);

        // Spacing 2: every other strobe is dropped.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);
        strobes(16, 2);
        idle(4);

        // Random traffic with enable toggling and acks.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(2) == 0), ($urandom_range(9) != 0), ($urandom_range(5) == 0),
                 1'($urandom), 1'b0);
        end
        idle(4);

        // Reset while the sequencer is in the Q-read state.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_selq", 32'(bus.rd_getQ), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("midrst_we", 32'(bus.ram_we), 32'd0);
        chk("midrst_didx", 32'(didx_o), 32'd7);
        chk("midrst_sel", 32'({bus.rd_getWB, bus.rd_getI, bus.rd_getQ}), 32'd0);
        chk("midrst_ovfl", 32'(ovfl_cnt), 32'd0);
        chk("midrst_waddr", 32'(waddr_o), 32'd0);
        idle(2);
        strobes(3, 4);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
